// File: rtl/interval_timer.sv
// rtl/interval_timer.sv - prescaled down-counting interval timer, one-shot or periodic
module interval_timer #(
    parameter int WIDTH   = 16,
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               periodic,
    input  logic [PRESC_W-1:0] presc,
    input  logic [WIDTH-1:0]   period,
    output logic               busy,
    output logic               done,
    output logic               tick,
    output logic [WIDTH-1:0]   count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [PRESC_W-1:0] pcnt;
    logic [PRESC_W-1:0] lat_presc;
    logic [WIDTH-1:0]   lat_period;
    logic               lat_periodic;

    logic accept;
    assign accept = start && !stop && (period != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            count        <= '0;
            pcnt         <= '0;
            tick         <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            lat_presc    <= '0;
            lat_period   <= '0;
            lat_periodic <= 1'b0;
        end else begin
            tick <= 1'b0;
            // stop outranks both a new start and an expiry landing on the same edge
            if (stop && state != IDLE) begin
                state <= IDLE;
                count <= '0;
                pcnt  <= '0;
                busy  <= 1'b0;
                done  <= 1'b0;
            end else if (accept) begin
                state        <= RUN;
                count        <= period;
                pcnt         <= '0;
                lat_presc    <= presc;
                lat_period   <= period;
                lat_periodic <= periodic;
                busy         <= 1'b1;
                done         <= 1'b0;
            end else if (state == RUN) begin
                if (pcnt == lat_presc) begin
                    pcnt <= '0;
                    if (count == WIDTH'(1)) begin
                        tick <= 1'b1;
                        if (lat_periodic) begin
                            count <= lat_period;
                        end else begin
                            count <= '0;
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else if (count != '0) begin
                        count <= count - WIDTH'(1);
                    end
                end else begin
                    pcnt <= pcnt + PRESC_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_interval_timer.sv
// tb/tb_interval_timer.sv - self-checking bench for interval_timer
module tb_interval_timer;

    localparam int WIDTH   = 16;
    localparam int PRESC_W = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               stop;
    logic               periodic;
    logic [PRESC_W-1:0] presc;
    logic [WIDTH-1:0]   period;
    logic               busy;
    logic               done;
    logic               tick;
    logic [WIDTH-1:0]   count;

    interval_timer #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .periodic(periodic),
        .presc(presc), .period(period), .busy(busy), .done(done), .tick(tick),
        .count(count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: time elapsed in the current interval, in clock cycles
    int m_state;     // 0 idle, 1 run, 2 done
    int m_elapsed;
    int m_presc;
    int m_period;
    bit m_periodic;
    bit m_tick;

    function automatic int m_count();
        if (m_state == 1) return m_period - m_elapsed / (m_presc + 1);
        return 0;
    endfunction

    task automatic model_reset();
        m_state = 0; m_elapsed = 0; m_presc = 0; m_period = 0; m_periodic = 0; m_tick = 0;
    endtask

    task automatic step(input bit s, input bit p, input bit per, input int pr, input int pd);
        start = s; stop = p; periodic = per; presc = PRESC_W'(pr); period = WIDTH'(pd);
        @(posedge clk);
        m_tick = 0;
        if (p && m_state != 0) begin
            m_state = 0;
        end else if (s && !p && pd != 0) begin
            m_state = 1; m_elapsed = 0; m_presc = pr; m_period = pd; m_periodic = per;
        end else if (m_state == 1) begin
            m_elapsed++;
            if (m_elapsed == m_period * (m_presc + 1)) begin
                m_tick = 1;
                if (m_periodic) m_elapsed = 0;
                else m_state = 2;
            end
        end
        #1;
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; stop = 0; periodic = 0; presc = '0; period = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_tests++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got %b want 0", tick); end
        n_tests++; if (count !== '0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        rst = 1'b0;
    endtask

    task automatic test_oneshot();
        int exp_cnt [4] = '{3, 2, 1, 0};
        step(1, 0, 0, 0, 3);
        for (int e = 0; e < 4; e++) begin
            if (e > 0) idle_step();
            n_tests++;
            if (count !== WIDTH'(exp_cnt[e])) begin
                n_fail++; $display("FAIL oneshot_count E%0d got %0d want %0d", e, count, exp_cnt[e]);
            end
            n_tests++;
            if (tick !== (e == 3) || busy !== (e != 3) || done !== (e == 3)) begin
                n_fail++; $display("FAIL oneshot_flags E%0d got tick=%b busy=%b done=%b", e, tick, busy, done);
            end
        end
        idle_step();
        n_tests++;
        if (tick !== 1'b0 || done !== 1'b1 || count !== '0) begin
            n_fail++; $display("FAIL oneshot_hold got tick=%b done=%b count=%0d want 0 1 0", tick, done, count);
        end
    endtask

    task automatic test_periodic();
        int ticks = 0;
        step(1, 0, 1, 3, 2);
        for (int c = 1; c <= 40; c++) begin
            idle_step();
            n_tests++;
            if (tick !== (c % 8 == 0) || busy !== 1'b1) begin
                n_fail++; $display("FAIL periodic_tick E%0d got tick=%b busy=%b want tick=%b busy=1", c, tick, busy, (c % 8 == 0));
            end
            n_tests++;
            if (count !== WIDTH'(m_count())) begin
                n_fail++; $display("FAIL periodic_count E%0d got %0d want %0d", c, count, m_count());
            end
            if (tick === 1'b1) ticks++;
        end
        n_tests++;
        if (ticks != 5) begin n_fail++; $display("FAIL periodic_ntick got %0d want 5", ticks); end
    endtask

    task automatic test_stop_on_expiry();
        step(1, 0, 1, 1, 2);
        repeat (3) idle_step();
        step(0, 1, 0, 0, 0);
        n_tests++;
        if (tick !== 1'b0 || busy !== 1'b0 || count !== '0 || done !== 1'b0) begin
            n_fail++; $display("FAIL stop_expiry got tick=%b busy=%b done=%b count=%0d want 0 0 0 0", tick, busy, done, count);
        end
        idle_step();
        n_tests++;
        if (tick !== 1'b0) begin n_fail++; $display("FAIL stop_late_tick got %b want 0", tick); end
    endtask

    task automatic test_zero_period_restart();
        int k = 0;
        step(1, 0, 1, 2, 0);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || tick !== 1'b0 || count !== '0) begin
            n_fail++; $display("FAIL zero_period got busy=%b done=%b tick=%b count=%0d want all 0", busy, done, tick, count);
        end
        step(1, 0, 1, 2, 4);
        repeat (4) idle_step();
        step(1, 0, 1, 2, 5);
        n_tests++;
        if (count !== WIDTH'(5)) begin n_fail++; $display("FAIL restart_count got %0d want 5", count); end
        for (int i = 1; i <= 100; i++) begin
            idle_step();
            if (tick === 1'b1) begin k = i; break; end
        end
        n_tests++;
        if (k != 15) begin n_fail++; $display("FAIL restart_latency got %0d want 15", k); end
    endtask

    task automatic test_start_stop_async_reset();
        step(1, 1, 0, 0, 7);
        n_tests++;
        if (busy !== 1'b0 || count !== '0) begin
            n_fail++; $display("FAIL start_stop got busy=%b count=%0d want 0 0", busy, count);
        end
        step(1, 0, 0, 3, 10);
        repeat (3) idle_step();
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || tick !== 1'b0 || count !== '0) begin
            n_fail++; $display("FAIL async_rst got busy=%b done=%b tick=%b count=%0d want all 0", busy, done, tick, count);
        end
        #1 rst = 1'b0;
        model_reset();
        idle_step();
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || count !== '0) begin
            n_fail++; $display("FAIL after_rst got busy=%b done=%b count=%0d want idle", busy, done, count);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0), 1'($urandom),
                 $urandom_range(0, 3), $urandom_range(0, 6));
            n_tests++;
            if (busy !== (m_state == 1) || done !== (m_state == 2) || tick !== m_tick ||
                count !== WIDTH'(m_count())) begin
                n_fail++;
                $display("FAIL random cyc%0d got busy=%b done=%b tick=%b count=%0d want %b %b %b %0d",
                         i, busy, done, tick, count, (m_state == 1), (m_state == 2), m_tick, m_count());
            end
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_stop_on_expiry();
        test_zero_period_restart();
        test_start_stop_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
